adder_accumulator: RTL

- Sequential multi-operand accumulator that sits directly downstream of the 4-bit ripple adder stage; it consumes the adder's 4-bit sum and carry-out and feeds the sum back as the next augend.
- Accepts a burst of N_OPS 4-bit operands, each with its own carry-in, over a valid/ready handshake.
- Produces the 4-bit running total, a count of carry-outs (wrap events), and a one-cycle done pulse.
- Addition semantics match the adder stage exactly: {cout, s} = a + b + cin.

---
 rtl/adder_accumulator.sv | 101 ++++++++++
 1 files changed

// File: rtl/adder_accumulator.sv
// Multi-operand accumulator downstream of the 4-bit ripple adder stage.
// Sums a burst of N_OPS operands and counts carry-out wrap events.
module adder_accumulator #(
    parameter int N_OPS = 4,
    parameter int OPC_W = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             din_valid,
    input  logic [3:0]       din,
    input  logic             cin,
    output logic             din_ready,
    output logic [3:0]       acc,
    output logic [CNT_W-1:0] carry_cnt,
    output logic             cnt_sat,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [OPC_W-1:0] OPS_LAST = OPC_W'(N_OPS - 1);

    state_t           state;
    state_t           state_nx;
    logic [OPC_W-1:0] op_cnt;
    logic [4:0]       sum;
    logic             xfer;
    logic             last;

    assign sum  = {1'b0, acc} + {1'b0, din} + {4'b0000, cin};
    assign xfer = (state == RUN) && din_valid;
    assign last = (op_cnt == OPS_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        din_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                din_ready = 1'b1;
                busy      = 1'b1;
                if (xfer && last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Results persist through IDLE; only a new start or rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            carry_cnt <= '0;
            cnt_sat   <= 1'b0;
            op_cnt    <= '0;
        end else if (state == IDLE && start) begin
            acc       <= '0;
            carry_cnt <= '0;
            cnt_sat   <= 1'b0;
            op_cnt    <= '0;
        end else if (xfer) begin
            acc    <= sum[3:0];
            op_cnt <= op_cnt + 1'b1;
            if (sum[4]) begin
                if (carry_cnt == CNT_MAX) begin
                    cnt_sat <= 1'b1;
                end else begin
                    carry_cnt <= carry_cnt + 1'b1;
                end
            end
        end
    end

endmodule
